// File: rtl/if_queue_if.sv
// ============================================================================
// Module      : if_queue_if
// Description : Handshake bundle between the fetch stage, the IF->ID queue and
//               the decode stage. The master side is the fetch/decode
//               pipeline; the slave side is the queue itself.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface if_queue_if #(
    parameter int CW = 3
);
    // Fetch -> queue
    logic          IF_over;
    logic [65:0]   IF_ID_bus;
    logic          IF_allow_in;

    // Queue -> decode
    logic          ID_allow_in;
    logic          ID_valid;
    logic [65:0]   ID_bus;

    // Pipeline control and status
    logic          flush;
    logic [CW-1:0] q_count;

    // Pipeline side: drives fetch results, decode acceptance and flush.
    modport master (
        output IF_over,
        output IF_ID_bus,
        output ID_allow_in,
        output flush,
        input  IF_allow_in,
        input  ID_valid,
        input  ID_bus,
        input  q_count
    );

    // Queue side.
    modport slave (
        input  IF_over,
        input  IF_ID_bus,
        input  ID_allow_in,
        input  flush,
        output IF_allow_in,
        output ID_valid,
        output ID_bus,
        output q_count
    );
endinterface

`default_nettype wire

// File: rtl/if_queue.sv
// ============================================================================
// Module      : if_queue
// Description : Circular-buffer instruction queue between IF and ID.
//               DEPTH entries of {pc, inst, fetch_error, delay_slot}.
//               flush discards every queued entry and wins over push/pop.
//               Optional macro IFQ_BYPASS_EN: when the queue is empty and
//               decode is ready, the fetched entry is forwarded to ID in the
//               same cycle without being written into the buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_queue #(
    parameter int DEPTH = 4,   // power of two, 2..16
    parameter int CW    = 3    // $clog2(DEPTH)+1
) (
    input  wire logic   clk,
    input  wire logic   resetn,
    if_queue_if.slave   q_if
);

    localparam int AW = $clog2(DEPTH);

    // Storage is never reset: ID_bus is gated by ID_valid so stale data
    // is never visible.
    logic [65:0]   mem_q [DEPTH];

    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    logic          w_stored_valid;
    logic          w_full;
    logic          w_allow_in;
    logic          w_push;
    logic          w_pop;
    logic          w_bypass;

    // Occupancy flags and the push/pop handshakes.
    always_comb begin
        w_stored_valid = (count_q != '0);
        w_full         = (count_q == CW'(DEPTH));
        // No pop credit when full: a full queue refuses pushes outright.
        w_allow_in     = ~w_full;
`ifdef IFQ_BYPASS_EN
        // Empty queue with decode ready: forward directly, store nothing.
        w_bypass       = ~w_stored_valid & q_if.IF_over & q_if.ID_allow_in
                         & ~q_if.flush;
`else
        w_bypass       = 1'b0;
`endif
        w_push         = q_if.IF_over & w_allow_in & ~q_if.flush & ~w_bypass;
        w_pop          = w_stored_valid & q_if.ID_allow_in & ~q_if.flush;
    end

    // Output side: head entry gated by valid (or the bypassed fetch entry).
    always_comb begin
        q_if.IF_allow_in = w_allow_in;
        q_if.q_count     = count_q;
`ifdef IFQ_BYPASS_EN
        q_if.ID_valid    = w_stored_valid | w_bypass;
        if (w_stored_valid) begin
            q_if.ID_bus = mem_q[rd_ptr_q];
        end else if (w_bypass) begin
            q_if.ID_bus = q_if.IF_ID_bus;
        end else begin
            q_if.ID_bus = 66'd0;
        end
`else
        // Only registered state reaches ID: minimum latency is one cycle.
        q_if.ID_valid    = w_stored_valid;
        q_if.ID_bus      = w_stored_valid ? mem_q[rd_ptr_q] : 66'd0;
`endif
    end

    // Next-state for pointers and occupancy; flush clears everything.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (q_if.flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (w_push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers, cleared asynchronously by resetn.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Write the fetched entry at the write pointer on an accepted push.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= q_if.IF_ID_bus;
        end
    end

endmodule

`default_nettype wire
